// File: rtl/affine_transform_core.sv
// Affine step x_next = A*x + U in binary32, nine sequential MACs on one shared fp mul/add.
// Optional feature macro AFFINE_BUSY_EN adds a busy output that is high while the FSM is in CALC.
module affine_transform_core #(
  parameter int PRECISION = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef AFFINE_BUSY_EN
  output logic                 busy,
`endif
  input  logic                 tvalid,
  input  logic [PRECISION-1:0] A00, A01, A02,
  input  logic [PRECISION-1:0] A10, A11, A12,
  input  logic [PRECISION-1:0] A20, A21, A22,
  input  logic [PRECISION-1:0] x0, x1, x2,
  input  logic [PRECISION-1:0] U0, U1, U2,
  output logic                 valid,
  output logic [PRECISION-1:0] x_next0, x_next1, x_next2
);

  typedef enum logic {IDLE, CALC} state_t;

  // Round-to-nearest-even on a 24-bit mantissa, then overflow to Inf or flush to zero.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [23:0] m, input logic g, input logic st);
    logic [24:0]       rnd;
    logic signed [9:0] ex;
    rnd = {1'b0, m} + {24'd0, g & (st | m[0])};
    ex  = e + $signed({9'd0, rnd[24]});
    if (ex >= 10'sd255)   return {s, 8'hFF, 23'd0};
    else if (ex <= 10'sd0) return {s, 31'd0};
    // On mantissa carry-out the fraction bits are already zero.
    return {s, ex[7:0], rnd[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sr, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic signed [9:0] ex;
    sr     = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    ex     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    else if (a_inf || b_inf)   return {sr, 8'hFF, 23'd0};
    else if (a_zero || b_zero) return {sr, 31'd0};
    else if (prod[47])         return fp_pack(sr, ex + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
    return fp_pack(sr, ex, prod[46:23], prod[22], |prod[21:0]);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       big, sml;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [7:0]        d;
    logic [5:0]        sh;
    logic [49:0]       wide;
    logic [26:0]       ax, bx, r;
    logic [27:0]       s28;
    logic [4:0]        pos, lz;
    logic signed [9:0] ex;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    big = a;
    sml = b;
    if (a[30:0] < b[30:0]) begin
      big = b;
      sml = a;
    end
    // Align the smaller operand keeping guard, round and a sticky OR of everything shifted out.
    d    = big[30:23] - sml[30:23];
    sh   = (d > 8'd49) ? 6'd49 : d[5:0];
    wide = {1'b1, sml[22:0], 26'd0} >> sh;
    bx   = {wide[49:24], |wide[23:0]};
    ax   = {1'b1, big[22:0], 3'b000};
    ex   = $signed({2'b00, big[30:23]});
    pos  = 5'd0;
    s28  = {1'b0, ax} + {1'b0, bx};
    if (big[31] == sml[31]) begin
      if (s28[27]) begin
        r  = {s28[27:2], |s28[1:0]};
        ex = ex + 10'sd1;
      end else begin
        r  = s28[26:0];
      end
    end else begin
      r = ax - bx;
      for (int k = 0; k < 27; k++)
        if (r[k]) pos = k[4:0];
      lz = 5'd26 - pos;
      r  = r << lz;
      ex = ex - $signed({5'd0, lz});
    end
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC0_0000;
    else if (a_inf)            return {a[31], 8'hFF, 23'd0};
    else if (b_inf)            return {b[31], 8'hFF, 23'd0};
    else if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    else if (a_zero)           return b;
    else if (b_zero)           return a;
    else if (r == 27'd0)       return 32'd0;
    return fp_pack(big[31], ex, r[26:3], r[2], |r[1:0]);
  endfunction

  state_t            state_q, state_d;
  logic [8:0][31:0]  a_q;
  logic [2:0][31:0]  x_q, acc_q, xn_q;
  logic [3:0]        step_q;
  logic              valid_q;
  logic              load, mac, done;
  logic [1:0]        row, col;
  logic [31:0]       mul_res, sum;

  always_comb begin
    row = 2'd0;
    col = step_q[1:0];
    if (step_q >= 4'd6) begin
      row = 2'd2;
      col = 2'(step_q - 4'd6);
    end else if (step_q >= 4'd3) begin
      row = 2'd1;
      col = 2'(step_q - 4'd3);
    end
    mul_res = fp_mul(a_q[step_q], x_q[col]);
    sum     = fp_add(acc_q[row], mul_res);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    mac     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (tvalid) begin
        load    = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        mac = 1'b1;
        if (step_q == 4'd8) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      xn_q    <= '0;
      step_q  <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= done;
      if (load) begin
        a_q    <= {A22, A21, A20, A12, A11, A10, A02, A01, A00};
        x_q    <= {x2, x1, x0};
        acc_q  <= {U2, U1, U0};
        step_q <= 4'd0;
      end
      if (mac) begin
        acc_q[row] <= sum;
        step_q     <= step_q + 4'd1;
      end
      // Last MAC lands in row 2, so take it straight from the adder.
      if (done) xn_q <= {sum, acc_q[1], acc_q[0]};
    end
  end

  assign valid   = valid_q;
  assign x_next0 = xn_q[0];
  assign x_next1 = xn_q[1];
  assign x_next2 = xn_q[2];
`ifdef AFFINE_BUSY_EN
  assign busy    = (state_q == CALC);
`endif

endmodule

// File: tb/tb_affine_transform_core.sv
// Directed vector bench for affine_transform_core; honours AFFINE_BUSY_EN when defined.
module tb_affine_transform_core;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             tvalid;
  logic [8:0][31:0] A;
  logic [2:0][31:0] X, U;
  logic             valid;
  wire  [31:0]      xn0, xn1, xn2;
  logic [2:0][31:0] xn;
`ifdef AFFINE_BUSY_EN
  logic             busy;
`endif

  assign xn = {xn2, xn1, xn0};

  always #5 clk = ~clk;

  affine_transform_core #(.PRECISION(32)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef AFFINE_BUSY_EN
    .busy(busy),
`endif
    .tvalid(tvalid),
    .A00(A[0]), .A01(A[1]), .A02(A[2]),
    .A10(A[3]), .A11(A[4]), .A12(A[5]),
    .A20(A[6]), .A21(A[7]), .A22(A[8]),
    .x0(X[0]), .x1(X[1]), .x2(X[2]),
    .U0(U[0]), .U1(U[1]), .U2(U[2]),
    .valid(valid),
    .x_next0(xn0), .x_next1(xn1), .x_next2(xn2)
  );

  typedef struct {
    logic [8:0][31:0] a;
    logic [2:0][31:0] x, u, e;
    logic [2:0]       chk;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_res(input int k, input string tag);
    for (int i = 0; i < 3; i++)
      if (vt[k].chk[i]) chk($sformatf("%s_v%0d_x_next%0d", tag, k, i), xn[i], vt[k].e[i]);
  endtask

  task automatic start(input int k);
    @(negedge clk);
    A = vt[k].a;
    X = vt[k].x;
    U = vt[k].u;
    tvalid = 1'b1;
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  // Returns cycles from the sampling edge to the edge that raised valid, -1 on timeout.
  task automatic wait_valid(input string tag);
    int n;
    bit seen;
    int busy_err;
    n = 0;
    seen = 0;
    busy_err = 0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1 n++;
      if (valid === 1'b1) seen = 1;
`ifdef AFFINE_BUSY_EN
      if (busy !== ~valid) busy_err++;
`endif
    end
    chk({tag, "_latency"}, seen ? n : -1, 32'd9);
`ifdef AFFINE_BUSY_EN
    chk({tag, "_busy_window"}, busy_err, 32'd0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   npulse, first, c;
    bit   seen_v, xn_nz;
    logic [2:0][31:0] cap;

    for (int k = 0; k < NV; k++) begin
      vt[k].a = '0; vt[k].x = '0; vt[k].u = '0; vt[k].e = '0; vt[k].chk = 3'b111;
    end
    // 0: identity
    vt[0].a[0] = 32'h3F800000; vt[0].a[4] = 32'h3F800000; vt[0].a[8] = 32'h3F800000;
    vt[0].x = {32'h40400000, 32'h40000000, 32'h3F800000};
    vt[0].u = {32'h3F000000, 32'h3F000000, 32'h3F000000};
    vt[0].e = {32'h40600000, 32'h40200000, 32'h3FC00000};
    // 1: PRNG matrix, only row 0 is hand-derived
    vt[1].a[1] = 32'h3F000000; vt[1].a[2] = 32'h3D4CCCCD; vt[1].a[3] = 32'h3EAAAAAB;
    vt[1].a[5] = 32'h3EAAAAAB; vt[1].a[6] = 32'h3D4CCCCD; vt[1].a[7] = 32'h3F000000;
    vt[1].x = {32'h0, 32'h3C23D70A, 32'h3DCCCCCD};
    vt[1].e[0] = 32'h3BA3D70A; vt[1].chk = 3'b001;
    // 2: exact cancellation to +0
    vt[2].a = {9{32'h40000000}};
    vt[2].x = {3{32'h3F800000}};
    vt[2].u = {3{32'hC0C00000}};
    // 3: +/- overflow and product underflow
    vt[3].a[0] = 32'h7F000000; vt[3].a[3] = 32'hFF000000; vt[3].a[8] = 32'h00800000;
    vt[3].x[0] = 32'h7F000000; vt[3].x[2] = 32'h00800000;
    vt[3].e = {32'h00000000, 32'hFF800000, 32'h7F800000};
    // 4: NaN operand, including 0*NaN
    vt[4].a[1] = 32'h3F800000; vt[4].x[1] = 32'h7FC00001;
    vt[4].e = {3{32'h7FC00000}};
    // 5: Inf*0, Inf-Inf, -2+2 -> +0
    vt[5].a[0] = 32'h7F800000; vt[5].a[4] = 32'hFF800000; vt[5].a[7] = 32'h40000000;
    vt[5].x[1] = 32'h3F800000;
    vt[5].u = {32'hC0000000, 32'h7F800000, 32'h0};
    vt[5].e = {32'h00000000, 32'h7FC00000, 32'h7FC00000};
    // 6: RNE tie-to-even, round-up, denormal flush, (-0)+(-0)
    vt[6].a[0] = 32'h3F800000; vt[6].a[4] = 32'h3F800000;
    vt[6].a[6] = 32'h80000000; vt[6].a[7] = 32'h80000000; vt[6].a[8] = 32'h80000000;
    vt[6].x = {32'h0, 32'h3F800000, 32'h3F800000};
    vt[6].u = {32'h80000001, 32'h33C00000, 32'h33800000};
    vt[6].e = {32'h80000000, 32'h3F800001, 32'h3F800000};

    reset_n = 1'b0; tvalid = 1'b0; A = '0; X = '0; U = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_x_next%0d", i), xn[i], 32'd0);
`ifdef AFFINE_BUSY_EN
    chk("reset_busy", {31'd0, busy}, 32'd0);
`endif
    @(negedge clk) reset_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      start(k);
      wait_valid($sformatf("vec%0d", k));
      chk_res(k, "vec");
      @(posedge clk);
      #1 chk($sformatf("vec%0d_valid_width", k), {31'd0, valid}, 32'd0);
      chk_res(k, "hold");
    end

    // Second strobe and new operands mid-calculation must be ignored.
    start(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = vt[2].a; X = vt[2].x; U = vt[2].u; tvalid = 1'b1;
    @(posedge clk);
    #1 tvalid = 1'b0;
    npulse = 0; first = -1; cap = '0;
    for (c = 5; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        npulse++;
        if (first < 0) begin first = c; cap = xn; end
      end
    end
    chk("ignore_pulse_count", npulse, 32'd1);
    chk("ignore_pulse_cycle", first, 32'd9);
    for (int i = 0; i < 3; i++) chk($sformatf("ignore_x_next%0d", i), cap[i], vt[0].e[i]);

    // Reset during step 4 aborts and clears the previous result.
    start(6);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("abort_x_next%0d", i), xn[i], 32'd0);
`ifdef AFFINE_BUSY_EN
    chk("abort_busy", {31'd0, busy}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen_v = 0; xn_nz = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0) seen_v = 1;
      if (xn !== '0) xn_nz = 1;
    end
    chk("abort_valid_seen", {31'd0, seen_v}, 32'd0);
    chk("abort_x_next_nonzero", {31'd0, xn_nz}, 32'd0);
    start(6);
    wait_valid("restart");
    chk_res(6, "restart");

    // Back-to-back: new strobe lands in the valid cycle.
    start(1);
    wait_valid("b2b_first");
    chk_res(1, "b2b_first");
    start(0);
    wait_valid("b2b_second");
    chk_res(0, "b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
